// File: rtl/idelay_load_seq.sv
// Shadow delay words per lane; on apply, loads dirty lanes one per cycle
// over a shared bus, then issues one common set strobe.
module idelay_load_seq #(
  parameter int NUM_LANES   = 8,
  parameter int LANE_AW     = 3,
  parameter int DELAY_VALUE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_we,
  input  logic [LANE_AW-1:0]   cmd_addr,
  input  logic [7:0]           cmd_data,
  input  logic                 cmd_apply,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 err_fine,
  output logic [7:0]           dly_data,
  output logic [NUM_LANES-1:0] dly_ld,
  output logic                 dly_set
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SET,
    FIN
  } state_t;

  localparam logic [7:0] RST_WORD = 8'(DELAY_VALUE);
  localparam logic [LANE_AW-1:0] LAST = LANE_AW'(NUM_LANES - 1);

  state_t state, state_nx;

  logic [7:0]           shadow [NUM_LANES];
  logic [NUM_LANES-1:0] dirty;
  logic [LANE_AW-1:0]   idx;
  logic                 pending;
  logic                 any_ld;
  logic                 wr_ok;
  logic                 fine_bad;
  logic [7:0]           wr_word;
  logic                 start;

  assign wr_ok    = cmd_we && (32'(cmd_addr) < 32'(NUM_LANES));
  assign fine_bad = cmd_data[2:0] > 3'd4;
  assign wr_word  = fine_bad ? {cmd_data[7:3], 3'd4} : cmd_data;
  assign start    = (state == IDLE) && (cmd_apply || pending);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (idx == LAST) state_nx = SET;
      SET:  state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) shadow[i] <= RST_WORD;
      dirty    <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      any_ld   <= 1'b0;
      err_fine <= 1'b0;
      done     <= 1'b0;
      dly_set  <= 1'b0;
      dly_ld   <= '0;
      dly_data <= RST_WORD;
    end else begin
      dly_ld  <= '0;
      dly_set <= 1'b0;
      done    <= 1'b0;

      if (wr_ok) begin
        shadow[cmd_addr] <= wr_word;
        dirty[cmd_addr]  <= 1'b1;
      end

      // a new violation wins over a simultaneous clear
      if (wr_ok && fine_bad) err_fine <= 1'b1;
      else if (err_clr)      err_fine <= 1'b0;

      if (state == IDLE) begin
        if (start) begin
          idx     <= '0;
          any_ld  <= 1'b0;
          pending <= 1'b0;
        end
      end else if (cmd_apply) begin
        pending <= 1'b1;
      end

      unique case (state)
        RUN: begin
          if (dirty[idx]) begin
            dly_ld   <= NUM_LANES'(1) << idx;
            dly_data <= shadow[idx];
            any_ld   <= 1'b1;
            // a same-cycle write keeps the lane dirty for the next pass
            if (!(wr_ok && cmd_addr == idx)) dirty[idx] <= 1'b0;
          end
          idx <= idx + 1'b1;
        end
        SET: dly_set <= any_ld;
        FIN: done    <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idelay_load_seq.sv
// Directed and random stimulus against a cycle-timed reference model
// of the lane load / set sequence.
module tb_idelay_load_seq;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DV = 'h22;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [7:0]   cmd_data;
  logic         cmd_apply;
  logic         err_clr;
  logic         busy;
  logic         done;
  logic         err_fine;
  logic [7:0]   dly_data;
  logic [N-1:0] dly_ld;
  logic         dly_set;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_sh [N];
  bit [N-1:0] m_dirty;
  bit         m_err, m_act, m_pend, m_any;
  int         m_t;
  logic [N-1:0] e_ld;
  logic [7:0] e_data;
  bit         e_set, e_done;

  idelay_load_seq #(
    .NUM_LANES(N),
    .LANE_AW(AW),
    .DELAY_VALUE(DV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_we(cmd_we),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_apply(cmd_apply),
    .err_clr(err_clr),
    .busy(busy),
    .done(done),
    .err_fine(err_fine),
    .dly_data(dly_data),
    .dly_ld(dly_ld),
    .dly_set(dly_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit we, input int a, input logic [7:0] d,
                            input bit ap, input bit clr, input bit r);
    bit bad;
    int k;
    if (!r) begin
      for (int i = 0; i < N; i++) m_sh[i] = 8'(DV);
      m_dirty = '0;
      m_err = 0; m_act = 0; m_pend = 0; m_any = 0; m_t = 0;
      e_ld = '0; e_data = 8'(DV); e_set = 0; e_done = 0;
      return;
    end
    e_ld = '0; e_set = 0; e_done = 0;
    if (m_act) begin
      m_t++;
      if (ap) m_pend = 1;
      if (m_t <= N) begin
        k = m_t - 1;
        if (m_dirty[k]) begin
          e_ld = N'(1) << k;
          e_data = m_sh[k];
          m_any = 1;
          m_dirty[k] = 0;
        end
      end else if (m_t == N + 1) begin
        e_set = m_any;
      end else begin
        e_done = 1;
        m_act = 0;
      end
    end else if (ap || m_pend) begin
      m_act = 1; m_t = 0; m_pend = 0; m_any = 0;
    end
    bad = we && (d[2:0] > 3'd4);
    if (we) begin
      m_sh[a] = bad ? {d[7:3], 3'd4} : d;
      m_dirty[a] = 1;
    end
    if (bad) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic cyc(input bit we, input int a, input logic [7:0] d,
                     input bit ap, input bit clr, input bit r);
    rst = r; cmd_we = we; cmd_addr = AW'(a); cmd_data = d;
    cmd_apply = ap; err_clr = clr;
    @(posedge clk);
    model_step(we, a, d, ap, clr, r);
    @(negedge clk);
    chk("dly_ld", 32'(dly_ld), 32'(e_ld));
    chk("dly_data", 32'(dly_data), 32'(e_data));
    chk("dly_set", 32'(dly_set), 32'(e_set));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(m_act));
    chk("err_fine", 32'(err_fine), 32'(m_err));
    chk("strobe_excl", 32'($onehot0(dly_ld) && !(|dly_ld && dly_set)), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(20);

    cyc(1, 2, 8'h2B, 0, 0, 1);
    cyc(1, 5, 8'h13, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    idle(14);

    cyc(1, 0, 8'h07, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    idle(12);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 4, 8'hFF, 0, 1, 1);
    idle(2);

    cyc(0, 0, 0, 1, 0, 1);
    idle(12);
    cyc(0, 0, 0, 1, 0, 1);
    idle(12);

    cyc(1, 3, 8'hA1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 3, 8'h5C, 0, 0, 1);
    idle(25);

    cyc(1, 1, 8'h55, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    idle(14);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, N - 1)),
          8'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 499) != 0);
    end
    idle(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
